// File: rtl/thermo_code_gen.sv
// thermo_code_gen
//   Binary-to-thermometer code generator used to stimulate the TDC
//   thermometer encoder during calibration and self-test. A code is loaded
//   through a valid/ready port, or a full 0..2**BIN_W-1 ramp is generated on
//   sweep_start. Each code is held valid for HOLD_CYCLES cycles.
//
//   Optional feature macro: THERMO_BUBBLE_EN
//     When defined, bubble_en/bubble_pos inject a single inverted bit into the
//     registered thermometer word on each code update (bin_echo stays clean).
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   in_valid      load request
//   in_ready      load accept (combinational)
//   in_bin        code to load, sampled on handshake
//   bubble_en     bubble injection enable        (THERMO_BUBBLE_EN only)
//   bubble_pos    bit position to invert          (THERMO_BUBBLE_EN only)
//   sweep_start   single-cycle ramp request
//   sweep_busy    high while the ramp is running
//   sweep_done    one-cycle pulse after the last ramp code
//   thermo        registered thermometer word
//   thermo_valid  high while a code is being held
//   bin_echo      binary code currently driven on thermo
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | nothing held; accepts loads and sweep requests
// HOLD  | holding a loaded code until cnt reaches zero
// SWEEP | stepping through every code, each held HOLD_CYCLES cycles

module thermo_code_gen #(
  parameter  int BIN_W       = 3,
  parameter  int HOLD_CYCLES = 4,
  localparam int THERMO_W    = 2**BIN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
`ifdef THERMO_BUBBLE_EN
  input  logic                bubble_en,
  input  logic [BIN_W-1:0]    bubble_pos,
`endif
  input  logic                sweep_start,
  output logic                sweep_busy,
  output logic                sweep_done,
  output logic [THERMO_W-1:0] thermo,
  output logic                thermo_valid,
  output logic [BIN_W-1:0]    bin_echo
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [BIN_W-1:0] CODE_MAX   = {BIN_W{1'b1}};

  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                valid_nxt, done_nxt;
  logic                load_code;
  logic [BIN_W-1:0]    code_sel;
  logic [THERMO_W-1:0] thermo_nxt;

  function automatic logic [THERMO_W-1:0] decode(input logic [BIN_W-1:0] code);
    logic [THERMO_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      t[i] = (i <= int'(code));
    end
    return t;
  endfunction

  // Optional fault injection applied to the freshly decoded word only, so the
  // held value does not get re-inverted on every cycle.
  function automatic logic [THERMO_W-1:0] shape(input logic [THERMO_W-1:0] t);
    logic [THERMO_W-1:0] r;
    r = t;
`ifdef THERMO_BUBBLE_EN
    if (bubble_en && (bubble_pos != '0)) begin
      r[bubble_pos] = ~t[bubble_pos];
    end
`else
    r = t;
`endif
    return r;
  endfunction

  // rst is folded in so nothing is accepted while reset is asserted.
  assign in_ready   = (state == IDLE) && !sweep_start && !rst;
  assign sweep_busy = (state == SWEEP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = thermo_valid;
    done_nxt  = 1'b0;
    load_code = 1'b0;
    code_sel  = bin_echo;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          load_code = 1'b1;
          code_sel  = '0;
          valid_nxt = 1'b1;
          cnt_nxt   = CNT_RELOAD;
          state_nxt = SWEEP;
        end else if (in_valid && in_ready) begin
          load_code = 1'b1;
          code_sel  = in_bin;
          valid_nxt = 1'b1;
          cnt_nxt   = CNT_RELOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      SWEEP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (bin_echo != CODE_MAX) begin
          load_code = 1'b1;
          code_sel  = bin_echo + BIN_W'(1);
          cnt_nxt   = CNT_RELOAD;
        end else begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    thermo_nxt = load_code ? shape(decode(code_sel)) : thermo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      thermo       <= '0;
      thermo_valid <= 1'b0;
      bin_echo     <= '0;
      sweep_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      thermo       <= thermo_nxt;
      thermo_valid <= valid_nxt;
      bin_echo     <= code_sel;
      sweep_done   <= done_nxt;
    end
  end

endmodule

// File: doc/thermo_code_gen.md
# thermo_code_gen

Binary-to-thermometer code generator with a handshake load port and a built-in ramp sweep. It turns a BIN_W-bit code into a registered 2**BIN_W-bit thermometer word and holds it for a programmable number of cycles. It drives the thermometer input of the TDC thermometer encoder during calibration and self-test. The generator emits `bin_echo` alongside the thermometer word so a scoreboard can compare it against the encoder's binary output.

## Interface
- BIN_W, 3, binary code width.
- THERMO_W, 2**BIN_W, thermometer width; derived, never overridden.
- HOLD_CYCLES, 4, cycles each code is held valid; legal range ≥1. Counter width is $clog2(HOLD_CYCLES+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  load request.
- in_ready  out  1  load accept; combinational, = (state==IDLE) & ~sweep_start & ~rst.
- in_bin  in  BIN_W  code to load; sampled on handshake.
- sweep_start  in  1  single-cycle request for a full 0..2**BIN_W-1 ramp.
- sweep_busy  out  1  high while in SWEEP.
- sweep_done  out  1  one-cycle registered pulse at end of sweep.
- thermo  out  THERMO_W  registered thermometer word; thermo[i] = 1 iff i ≤ code.
- thermo_valid  out  1  registered; high while a code is being held.
- bin_echo  out  BIN_W  registered code currently driven on thermo.
- bubble_en, bubble_pos  in  1, BIN_W  only present with THERMO_BUBBLE_EN.

## Operation
- The FSM has three states: IDLE, HOLD and SWEEP. The hold counter is `cnt`.
- **IDLE with sweep_start=1:**
  - code=0 goes to thermo and bin_echo.
  - thermo_valid=1, cnt=HOLD_CYCLES-1, next state is SWEEP.
  - sweep_start beats in_valid; in_ready is low that cycle, so in_bin is not consumed.
- **IDLE with a handshake (in_valid & in_ready):**
  - in_bin is decoded to thermo and copied to bin_echo.
  - thermo_valid=1, cnt=HOLD_CYCLES-1, next state is HOLD.
- **HOLD:**
  - If cnt≠0, decrement.
  - If cnt==0, go to IDLE and clear thermo_valid. thermo and bin_echo keep their last value.
  - sweep_start and in_valid are ignored.
- **SWEEP:**
  - If cnt≠0, decrement.
  - If cnt==0 and code<2**BIN_W-1, increment code, update thermo and bin_echo, and reload cnt.
  - If cnt==0 and code==2**BIN_W-1, go to IDLE, clear thermo_valid and pulse sweep_done. There is no wrap-around.
  - sweep_start and in_valid are ignored; in_ready=0.
- **Decode rule:** thermo[0] is 1 for every valid code.
  - Code k gives k+1 ones from the LSB.
  - Code 0 = 0x01, code 2**BIN_W-1 = all ones.
- **Reset values:**
  - thermo=0 (all bits, including bit 0), thermo_valid=0, bin_echo=0.
  - sweep_busy=0, sweep_done=0, state IDLE, cnt=0.
- **Reset mid-operation:** any hold or sweep is aborted immediately and asynchronously, and all outputs go to their reset values. There is no resume.

## Timing
- Load latency is 1 cycle: handshake at edge N makes thermo, bin_echo and thermo_valid valid after edge N.
- thermo_valid is high for exactly HOLD_CYCLES consecutive cycles per load.
- in_ready returns high in the first cycle after thermo_valid falls. Minimum load spacing is HOLD_CYCLES+1 cycles.
- Sweep timing:
  - thermo_valid is high continuously for 2**BIN_W × HOLD_CYCLES cycles.
  - Each code step lands on the edge following the cycle with cnt==0.
  - sweep_done is high in the first cycle after thermo_valid falls.
  - sweep_busy falls at the same edge as thermo_valid.
- All outputs except in_ready are registered; there are no combinational paths from inputs to thermo.

## Configuration
- THERMO_BUBBLE_EN is defined: the bubble_en and bubble_pos ports exist.
  - On every code update (load or sweep step) where bubble_en=1 and bubble_pos≠0, thermo[bubble_pos] is inverted in the registered word.
  - bin_echo is unchanged, so the scoreboard still expects the clean code.
  - bubble_en and bubble_pos are sampled at the same edge as the code update.
- THERMO_BUBBLE_EN is undefined: the ports are absent and thermo is always a clean thermometer code.

## Test plan
- **Reset:** assert rst mid-cycle → thermo=0x00, thermo_valid=0, bin_echo=0 and sweep_done=0 immediately; in_ready=1 in the first cycle after release.
- **Single load, BIN_W=3, HOLD_CYCLES=4:** in_bin=5 handshake → next cycle thermo=0x3F, bin_echo=5, thermo_valid high 4 cycles, in_ready low 4 cycles, then in_ready=1 and thermo still 0x3F.
- **End codes:** in_bin=0 → thermo=0x01; in_bin=7 → thermo=0xFF; both with thermo_valid for 4 cycles.
- **Sweep:** pulse sweep_start → thermo steps 0x01, 0x03, 0x07 … 0xFF, each held 4 cycles (32 valid cycles total) → sweep_done for 1 cycle after; in_valid asserted mid-sweep is never accepted.
- **Simultaneous requests:** sweep_start and in_valid in the same IDLE cycle with in_bin=6 → in_ready=0, sweep starts at 0x01, and in_bin=6 is accepted only after sweep_done.
- **Reset mid-sweep and bubble injection:**
  - rst during code 3 → immediate thermo=0x00, sweep_busy=0, no sweep_done.
  - With THERMO_BUBBLE_EN: in_bin=6, bubble_en=1, bubble_pos=3 → thermo=0x77, bin_echo=6.
